// File: rtl/logic_unit_pkg.sv
// Shared types for the pipelined logic unit: op encodings and burst FSM states.
package logic_unit_pkg;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_XOR    = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_NOT_A  = 3'd6,
    OP_PASS_A = 3'd7
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

endpackage

// File: rtl/logic_op_eval.sv
// Combinational bitwise evaluator: res_c = op(x, y).
module logic_op_eval
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] res_c
);

  always_comb begin
    res_c = '0;
    case (op)
      OP_AND:    res_c = x & y;
      OP_OR:     res_c = x | y;
      OP_XOR:    res_c = x ^ y;
      OP_NAND:   res_c = ~(x & y);
      OP_NOR:    res_c = ~(x | y);
      OP_XNOR:   res_c = ~(x ^ y);
      OP_NOT_A:  res_c = ~x;
      OP_PASS_A: res_c = x;
      default:   res_c = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Streaming two-operand logic unit with registered valid/ready output stage
// and a burst accumulate mode that folds one latched op across several beats.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic             out_red_and,
  output logic             out_red_or,
  output logic             out_red_xor,
  output logic             out_err
);

  state_e           state, state_next;
  logic [WIDTH-1:0] acc, acc_next;
  op_e              op_q, op_next;
  logic             fire;
  logic             chain;
  logic             produce_c;
  logic             err_c;
  op_e              eval_op;
  logic [WIDTH-1:0] eval_x, eval_y, eval_res;

  assign in_ready = !out_valid || out_ready;
  assign fire     = in_valid && in_ready;

  // Continuing a burst folds the accumulator with A under the op latched on its first beat.
  assign chain   = (state == ACC) && in_acc;
  assign eval_op = chain ? op_q : op_e'(in_op);
  assign eval_x  = chain ? acc  : in_a;
  assign eval_y  = chain ? in_a : in_b;

  logic_op_eval #(.WIDTH(WIDTH)) u_eval (
    .op    (eval_op),
    .x     (eval_x),
    .y     (eval_y),
    .res_c (eval_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      op_q  <= OP_AND;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      op_q  <= op_next;
    end
  end

  always_comb begin
    state_next = state;
    acc_next   = acc;
    op_next    = op_q;
    produce_c  = 1'b0;
    err_c      = 1'b0;
    if (fire) begin
      case (state)
        IDLE: begin
          if (in_acc && !in_last) begin
            acc_next   = eval_res;
            op_next    = op_e'(in_op);
            state_next = ACC;
          end else begin
            produce_c = 1'b1;
          end
        end
        ACC: begin
          if (in_acc) begin
            if (in_last) begin
              produce_c  = 1'b1;
              acc_next   = '0;
              state_next = IDLE;
            end else begin
              acc_next = eval_res;
            end
          end else begin
            // Burst abandoned: drop the partial result and treat the beat as a normal one.
            err_c      = 1'b1;
            produce_c  = 1'b1;
            acc_next   = '0;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Output stage: new results replace a consumed one in the same cycle, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_y       <= '0;
      out_red_and <= 1'b0;
      out_red_or  <= 1'b0;
      out_red_xor <= 1'b0;
      out_err     <= 1'b0;
    end else begin
      out_err <= err_c;
      if (produce_c) begin
        out_valid   <= 1'b1;
        out_y       <= eval_res;
        out_red_and <= &eval_res;
        out_red_or  <= |eval_res;
        out_red_xor <= ^eval_res;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: directed spec scenarios plus random bursts.
module tb_logic_unit_pipe;

  localparam int unsigned WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic [2:0]       in_op = '0;
  logic             in_acc = 1'b0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_y;
  logic             out_red_and, out_red_or, out_red_xor;
  logic             out_err;

  logic_unit_pipe #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_op       (in_op),
    .in_acc      (in_acc),
    .in_last     (in_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_y       (out_y),
    .out_red_and (out_red_and),
    .out_red_or  (out_red_or),
    .out_red_xor (out_red_xor),
    .out_err     (out_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic rand_ready = 1'b0;

  typedef struct {
    logic [WIDTH-1:0] y;
    logic             r_and;
    logic             r_or;
    logic             r_xor;
  } result_t;

  result_t exp_q[$];

  // Reference model state
  logic             m_burst = 1'b0;
  logic [WIDTH-1:0] m_acc = '0;
  int               m_op = 0;
  logic             exp_valid = 1'b0;
  logic             err_exp = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [WIDTH-1:0] ref_op(int op, logic [WIDTH-1:0] x, logic [WIDTH-1:0] y);
    case (op)
      0: return x & y;
      1: return x | y;
      2: return x ^ y;
      3: return ~(x & y);
      4: return ~(x | y);
      5: return ~(x ^ y);
      6: return ~x;
      default: return x;
    endcase
  endfunction

  function automatic void push_result(logic [WIDTH-1:0] v);
    result_t r;
    r.y     = v;
    r.r_and = &v;
    r.r_or  = |v;
    r.r_xor = ^v;
    exp_q.push_back(r);
    exp_valid = 1'b1;
  endfunction

  // Monitor + model: check presented output, retire consumed results, then model the accepted beat.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_burst   = 1'b0;
      m_acc     = '0;
      m_op      = 0;
      exp_valid = 1'b0;
      err_exp   = 1'b0;
      chk("reset_out_valid", 32'(out_valid), 32'(0));
      chk("reset_out_err", 32'(out_err), 32'(0));
    end else begin
      chk("out_err", 32'(out_err), 32'(err_exp));
      chk("out_valid", 32'(out_valid), 32'(exp_valid));
      chk("in_ready", 32'(in_ready), 32'(!exp_valid || out_ready));
      if (exp_valid && exp_q.size() > 0) begin
        chk("out_y", 32'(out_y), 32'(exp_q[0].y));
        chk("out_red", 32'({out_red_and, out_red_or, out_red_xor}),
            32'({exp_q[0].r_and, exp_q[0].r_or, exp_q[0].r_xor}));
        if (out_ready) begin
          void'(exp_q.pop_front());
          exp_valid = 1'b0;
        end
      end
      err_exp = 1'b0;
      if (in_valid && (!exp_valid || out_ready)) begin
        if (m_burst) begin
          if (in_acc) begin
            if (in_last) begin
              push_result(ref_op(m_op, m_acc, in_a));
              m_burst = 1'b0;
            end else begin
              m_acc = ref_op(m_op, m_acc, in_a);
            end
          end else begin
            err_exp = 1'b1;
            m_burst = 1'b0;
            push_result(ref_op(int'(in_op), in_a, in_b));
          end
        end else if (in_acc && !in_last) begin
          m_acc   = ref_op(int'(in_op), in_a, in_b);
          m_op    = int'(in_op);
          m_burst = 1'b1;
        end else begin
          push_result(ref_op(int'(in_op), in_a, in_b));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Present one beat and return 1 time unit after the edge that accepted it.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input int op,
                      input logic acc, input logic last);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = 3'(op);
    in_acc   = acc;
    in_last  = last;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stuck 0 expected 1 at %0t", $time);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] sweep [8];
    logic [7:0] red_a [3];
    logic [2:0] red_e [3];
    int         w;
    sweep = '{8'h42, 8'hDB, 8'h99, 8'hBD, 8'h24, 8'h66, 8'h3C, 8'hC3};
    red_a = '{8'h00, 8'hFF, 8'h30};
    red_e = '{3'b000, 3'b110, 3'b010};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_y", 32'(out_y), 32'(0));
    chk("reset_red", 32'({out_red_and, out_red_or, out_red_xor}), 32'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Truth sweep, one-cycle latency
    for (int op = 0; op < 8; op++) begin
      send(8'hC3, 8'h5A, op, 1'b0, 1'b0);
      chk("sweep_valid", 32'(out_valid), 32'(1));
      chk("sweep_y", 32'(out_y), 32'(sweep[op]));
    end

    // Reductions
    for (int i = 0; i < 3; i++) begin
      send(red_a[i], 8'h00, 7, 1'b0, 1'b0);
      chk("red_bits", 32'({out_red_and, out_red_or, out_red_xor}), 32'(red_e[i]));
    end

    // Accumulate AND burst
    send(8'hFF, 8'hF3, 0, 1'b1, 1'b0);
    chk("acc_no_out1", 32'(out_valid), 32'(0));
    send(8'h3C, 8'h00, 1, 1'b1, 1'b0);
    chk("acc_no_out2", 32'(out_valid), 32'(0));
    send(8'h31, 8'h00, 2, 1'b1, 1'b1);
    chk("acc_valid", 32'(out_valid), 32'(1));
    chk("acc_y", 32'(out_y), 32'(8'h30));

    // Back-pressure then release with a beat waiting
    send(8'hC3, 8'h5A, 0, 1'b0, 1'b0);
    out_ready = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
      chk("bp_in_ready", 32'(in_ready), 32'(0));
      chk("bp_y", 32'(out_y), 32'(8'h42));
    end
    out_ready = 1'b1;
    send(8'hC3, 8'h5A, 1, 1'b0, 1'b0);
    chk("bp_release_valid", 32'(out_valid), 32'(1));
    chk("bp_release_y", 32'(out_y), 32'(8'hDB));

    // Abort a burst with a normal beat
    send(8'hF0, 8'hFF, 0, 1'b1, 1'b0);
    send(8'h0F, 8'h01, 2, 1'b0, 1'b0);
    chk("abort_err", 32'(out_err), 32'(1));
    chk("abort_y", 32'(out_y), 32'(8'h0E));
    @(posedge clk);
    #1;
    chk("abort_err_pulse", 32'(out_err), 32'(0));
    send(8'hAA, 8'h0F, 0, 1'b1, 1'b1);
    chk("abort_idle_y", 32'(out_y), 32'(8'h0A));

    // Reset in the middle of a burst
    send(8'hAA, 8'h0F, 0, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(out_valid), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_no_out", 32'(out_valid), 32'(0));
    send(8'h0F, 8'h01, 2, 1'b0, 1'b0);
    chk("rst_after_y", 32'(out_y), 32'(8'h0E));
    chk("rst_after_err", 32'(out_err), 32'(0));

    // Random traffic with random back-pressure and bursts
    rand_ready = 1'b1;
    for (int i = 0; i < 600; i++) begin
      logic acc_b;
      acc_b = ($urandom_range(0, 2) == 0) || m_burst;
      if ($urandom_range(0, 9) == 0) acc_b = 1'b0;
      send(8'($urandom), 8'($urandom), int'($urandom_range(0, 7)), acc_b,
           ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;

    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'(0));
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
